// File: rtl/eth_csum_pkg.sv
// Shared types and field positions for the TX checksum insert path.
// Used by eth_csum_desc_fifo and eth_csum_insert.
package eth_csum_pkg;

  localparam int C_FIFO_W  = 73;
  localparam int TLAST_BIT = 72;
  localparam int TKEEP_LO  = 64;

  localparam int DESC_W      = 33;
  localparam int DESC_EN_BIT = 32;
  localparam int DESC_OFF_HI = 31;
  localparam int DESC_OFF_LO = 16;
  localparam int DESC_SUM_HI = 15;
  localparam int DESC_SUM_LO = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // Byte lanes are little-endian within a beat: lane 0 is bits [7:0].
  function automatic logic [63:0] set_lane(input logic [63:0] word,
                                           input logic [2:0]  lane,
                                           input logic [7:0]  value);
    logic [63:0] result;
    result = word;
    result[{lane, 3'b000} +: 8] = value;
    return result;
  endfunction

endpackage

// File: rtl/eth_csum_desc_fifo.sv
// Synchronous first-word-fall-through FIFO holding per-frame checksum descriptors.
// Writes while full are discarded; the owner flags the overflow.
module eth_csum_desc_fifo
  import eth_csum_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DESC_W-1:0] wdata,
  input  logic              rd,
  output logic [DESC_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DESC_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // One extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/eth_csum_insert.sv
// Patches a per-frame 16-bit checksum into frames popped from the data FIFO and streams them out.
// Optional statistics counters are enabled with ETH_CSUM_INSERT_STATS_EN.
module eth_csum_insert
  import eth_csum_pkg::*;
#(
  parameter int C_DESC_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_FIFO_W-1:0] data_fifo_rdata,
  input  logic                data_fifo_empty,
  output logic                data_fifo_rden,
  input  logic                desc_wr,
  input  logic [DESC_W-1:0]   desc_wdata,
  output logic                desc_full,
  output logic [63:0]         m_tdata,
  output logic [7:0]          m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                csum_oob,
  output logic                desc_ovf
`ifdef ETH_CSUM_INSERT_STATS_EN
  ,
  output logic [31:0]         stat_frames,
  output logic [31:0]         stat_oob
`endif
);

  state_t            state;
  logic              desc_empty;
  logic              desc_rd;
  logic [DESC_W-1:0] desc_rdata;

  logic              cs_en;
  logic [15:0]       cs_off;
  logic [15:0]       cs_sum;
  logic [12:0]       bcnt;
  logic              hi_done;
  logic              lo_done;

  logic              in_last;
  logic [7:0]        in_keep;
  logic [63:0]       in_data;
  logic [16:0]       lo_off;
  logic              hi_hit;
  logic              lo_hit;
  logic              oob_now;
  logic [63:0]       patched;

  eth_csum_desc_fifo #(
    .DEPTH (C_DESC_DEPTH)
  ) u_desc_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (desc_wr),
    .wdata (desc_wdata),
    .rd    (desc_rd),
    .rdata (desc_rdata),
    .full  (desc_full),
    .empty (desc_empty)
  );

  assign desc_rd        = (state == ST_IDLE) & ~desc_empty;
  assign data_fifo_rden = (state == ST_FRAME) & ~data_fifo_empty & (~m_tvalid | m_tready);

  assign in_last = data_fifo_rdata[TLAST_BIT];
  assign in_keep = data_fifo_rdata[TLAST_BIT-1:TKEEP_LO];
  assign in_data = data_fifo_rdata[TKEEP_LO-1:0];

  // The low byte may spill into lane 0 of the next beat; bit 16 marks an offset past 64 KiB.
  assign lo_off = {1'b0, cs_off} + 17'd1;
  assign hi_hit = cs_en && (bcnt == cs_off[15:3]) && in_keep[cs_off[2:0]];
  assign lo_hit = cs_en && !lo_off[16] && (bcnt == lo_off[15:3]) && in_keep[lo_off[2:0]];
  assign oob_now = cs_en && (!(hi_done || hi_hit) || !(lo_done || lo_hit));

  always_comb begin
    patched = in_data;
    if (hi_hit) patched = set_lane(patched, cs_off[2:0], cs_sum[15:8]);
    if (lo_hit) patched = set_lane(patched, lo_off[2:0], cs_sum[7:0]);
  end

  // Frame sequencing and the output register share one block so every output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cs_en    <= 1'b0;
      cs_off   <= '0;
      cs_sum   <= '0;
      bcnt     <= '0;
      hi_done  <= 1'b0;
      lo_done  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
      csum_oob <= 1'b0;
      desc_ovf <= 1'b0;
    end else begin
      csum_oob <= 1'b0;
      if (desc_wr && desc_full) desc_ovf <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!desc_empty) begin
            cs_en   <= desc_rdata[DESC_EN_BIT];
            cs_off  <= desc_rdata[DESC_OFF_HI:DESC_OFF_LO];
            cs_sum  <= desc_rdata[DESC_SUM_HI:DESC_SUM_LO];
            bcnt    <= '0;
            hi_done <= 1'b0;
            lo_done <= 1'b0;
            state   <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (data_fifo_rden) begin
            bcnt    <= bcnt + 13'd1;
            hi_done <= hi_done | hi_hit;
            lo_done <= lo_done | lo_hit;
            if (in_last) begin
              csum_oob <= oob_now;
              state    <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (data_fifo_rden) begin
        m_tdata  <= patched;
        m_tkeep  <= in_keep;
        m_tlast  <= in_last;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

`ifdef ETH_CSUM_INSERT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_oob    <= '0;
    end else if (data_fifo_rden && in_last && state == ST_FRAME) begin
      stat_frames <= stat_frames + 32'd1;
      if (oob_now) stat_oob <= stat_oob + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_csum_insert.sv
// Scoreboard bench for eth_csum_insert: stimulus queues expected beats, a negedge monitor checks them.
// Covers straddled, truncated and disabled inserts, backpressure, start latency and descriptor overflow.
module tb_eth_csum_insert;
  import eth_csum_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [C_FIFO_W-1:0] data_fifo_rdata = '0;
  logic                data_fifo_empty = 1'b1;
  logic                data_fifo_rden;
  logic                desc_wr = 1'b0;
  logic [DESC_W-1:0]   desc_wdata = '0;
  logic                desc_full;
  logic [63:0]         m_tdata;
  logic [7:0]          m_tkeep;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready = 1'b0;
  logic                csum_oob;
  logic                desc_ovf;
`ifdef ETH_CSUM_INSERT_STATS_EN
  logic [31:0]         stat_frames;
  logic [31:0]         stat_oob;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int readyMode  = 0;
  bit popNow     = 1'b0;
  bit oobPending = 1'b0;

  logic [C_FIFO_W-1:0] dataQ[$];
  logic [C_FIFO_W-1:0] expQ[$];
  bit                  oobQ[$];

  eth_csum_insert #(
    .C_DESC_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .desc_wr         (desc_wr),
    .desc_wdata      (desc_wdata),
    .desc_full       (desc_full),
    .m_tdata         (m_tdata),
    .m_tkeep         (m_tkeep),
    .m_tlast         (m_tlast),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .csum_oob        (csum_oob),
    .desc_ovf        (desc_ovf)
`ifdef ETH_CSUM_INSERT_STATS_EN
    ,
    .stat_frames     (stat_frames),
    .stat_oob        (stat_oob)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [C_FIFO_W-1:0] actual,
                             input logic [C_FIFO_W-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
  endtask

  // Data FIFO model: head is refreshed after the pop decided at the previous negedge.
  always @(posedge clk) begin
    logic [C_FIFO_W-1:0] dropped;
    #1;
    if (popNow && dataQ.size() > 0) dropped = dataQ.pop_front();
    #1;
    data_fifo_empty = (dataQ.size() == 0);
    data_fifo_rdata = data_fifo_empty ? '0 : dataQ[0];
  end

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ~m_tready;
    endcase
  end

  // Monitor: output beats and csum_oob pulses are compared against the scoreboard queues.
  always @(negedge clk) begin
    if (oobPending) begin
      oobPending = 1'b0;
      if (oobQ.size() == 0) checkOutput("oob_queue_empty", 1, 0);
      else checkOutput("csum_oob", csum_oob, oobQ.pop_front());
    end else if (csum_oob) begin
      checkOutput("csum_oob_spurious", csum_oob, 0);
    end
    if (data_fifo_rden && data_fifo_rdata[TLAST_BIT]) oobPending = 1'b1;
    popNow = data_fifo_rden;
    if (m_tvalid && m_tready) begin
      if (expQ.size() == 0) checkOutput("unexpected_beat", {m_tlast, m_tkeep, m_tdata}, '0);
      else checkOutput("beat", {m_tlast, m_tkeep, m_tdata}, expQ.pop_front());
    end
  end

  // Frame byte k carries seed+k; expected copy gets hi/lo checksum bytes at off/off+1 when present.
  task automatic loadFrame(input int nbytes, input logic [7:0] seed, input logic en,
                           input logic [15:0] off, input logic [15:0] sum);
    int nbeats;
    int o;
    logic [63:0] d;
    logic [63:0] e;
    logic [7:0]  keep;
    logic        last;
    nbeats = (nbytes + 7) / 8;
    o = int'(off);
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      e = '0;
      keep = '0;
      for (int l = 0; l < 8; l++) begin
        int k;
        k = b * 8 + l;
        if (k < nbytes) begin
          keep[l] = 1'b1;
          d[l*8 +: 8] = seed + 8'(k);
          e[l*8 +: 8] = d[l*8 +: 8];
          if (en && k == o)     e[l*8 +: 8] = sum[15:8];
          if (en && k == o + 1) e[l*8 +: 8] = sum[7:0];
        end
      end
      last = (b == nbeats - 1);
      dataQ.push_back({last, keep, d});
      expQ.push_back({last, keep, e});
    end
    oobQ.push_back(en && !((o < nbytes) && (o + 1 < nbytes)));
  endtask

  task automatic pushDesc(input logic en, input logic [15:0] off, input logic [15:0] sum);
    desc_wr    = 1'b1;
    desc_wdata = {en, off, sum};
    @(posedge clk); #1;
    desc_wr    = 1'b0;
  endtask

  task automatic applyStimulus(input int nbytes, input logic [7:0] seed, input logic en,
                               input logic [15:0] off, input logic [15:0] sum);
    loadFrame(nbytes, seed, en, off, sum);
    pushDesc(en, off, sum);
  endtask

  task automatic waitDrain(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      if (expQ.size() == 0 && oobQ.size() == 0 && dataQ.size() == 0 && !oobPending) break;
      @(posedge clk); #1;
    end
    if (i >= 400) checkOutput(name, 1, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", m_tvalid, 0);
    checkOutput("rst_out", {m_tlast, m_tkeep, m_tdata}, '0);
    checkOutput("rst_oob", csum_oob, 0);
    checkOutput("rst_ovf", desc_ovf, 0);
    checkOutput("rst_desc_full", desc_full, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    readyMode = 1;

    $display("[TB] test1: 64B frame, insert at offset 24");
    applyStimulus(64, 8'h00, 1'b1, 16'd24, 16'hBEEF);
    waitDrain("drain_t1");

    $display("[TB] test2: insert straddling beat 1 / beat 2");
    applyStimulus(32, 8'h40, 1'b1, 16'd15, 16'h1234);
    waitDrain("drain_t2");

    $display("[TB] test3: 20B frame, low byte beyond end");
    applyStimulus(20, 8'h80, 1'b1, 16'd19, 16'hA5A5);
    waitDrain("drain_t3");

    $display("[TB] test4: back-to-back frames with toggling ready");
    readyMode = 2;
    applyStimulus(48, 8'h10, 1'b1, 16'd30, 16'hC0DE);
    applyStimulus(27, 8'h20, 1'b0, 16'd2,  16'hDEAD);
    applyStimulus(16, 8'h30, 1'b1, 16'd0,  16'h0102);
    waitDrain("drain_t4");
    readyMode = 1;
    @(posedge clk); #1;

    $display("[TB] test5: data waiting without descriptor");
    loadFrame(24, 8'h50, 1'b1, 16'd8, 16'h5A5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("no_desc_idle", {data_fifo_rden, m_tvalid}, 2'b00);
      @(posedge clk); #1;
    end
    pushDesc(1'b1, 16'd8, 16'h5A5A);
    @(posedge clk);
    @(negedge clk);
    checkOutput("start_latency_early", m_tvalid, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("start_latency", m_tvalid, 1);
    @(posedge clk); #1;
    waitDrain("drain_t5");

    $display("[TB] test6: descriptor overflow and reset mid-frame");
    readyMode = 0;
    @(posedge clk); #1;
    dataQ.push_back({1'b0, 8'hFF, 64'h0706050403020100});
    dataQ.push_back({1'b0, 8'hFF, 64'h0F0E0D0C0B0A0908});
    pushDesc(1'b1, 16'd0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) pushDesc(1'b1, 16'(i), 16'(16'h1000 + i));
    @(negedge clk);
    checkOutput("desc_full", desc_full, 1);
    checkOutput("desc_ovf", desc_ovf, 1);
    checkOutput("held_tvalid", m_tvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_midframe_tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dataQ.delete();
    expQ.delete();
    oobQ.delete();
    @(negedge clk);
    checkOutput("post_rst_desc_full", desc_full, 0);
    checkOutput("post_rst_ovf", desc_ovf, 0);
    @(posedge clk); #1;

    readyMode = 1;
    applyStimulus(16, 8'h70, 1'b1, 16'd6, 16'hFACE);
    waitDrain("drain_t6");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
